// File: rtl/rv_lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// the request legality check.
package rv_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WRITE,
        S_RESP
    } lsu_state_e;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_MISALIGN,
        ERR_RANGE,
        ERR_FUNCT3
    } lsu_err_e;

    // Classifies a request; funct3 legality is checked first so alignment
    // rules are only applied to sizes that actually exist.
    function automatic lsu_err_e lsu_check_req(input logic we, input logic [2:0] funct3,
                                               input logic [31:0] addr,
                                               input int unsigned mem_words);
        logic legal;
        legal = we ? (funct3 inside {F3_B, F3_H, F3_W})
                   : (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        if (!legal)
            return ERR_FUNCT3;
        if (((funct3 == F3_H || funct3 == F3_HU) && addr[0]) ||
            (funct3 == F3_W && addr[1:0] != 2'b00))
            return ERR_MISALIGN;
        if ({2'b00, addr[31:2]} >= 32'(mem_words))
            return ERR_RANGE;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: load extract/extend and sub-word store
// merge into the current memory word (little-endian lanes).
module lsu_lane_align
    import rv_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[{offset, 3'b000} +: 8];
        half_v = offset[1] ? word[31:16] : word[15:0];

        load_data = word;
        case (funct3)
            F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
            F3_BU:   load_data = {24'h000000, byte_v};
            F3_H:    load_data = {{16{half_v[15]}}, half_v};
            F3_HU:   load_data = {16'h0000, half_v};
            default: load_data = word;
        endcase

        store_word = word;
        case (funct3)
            F3_B:    store_word[{offset, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    store_word[{offset[1], 4'b0000} +: 16] = wdata;
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns RISC-V byte/half/word requests into single-word
// memory accesses, using read-modify-write for sub-word stores.
module load_store_unit
    import rv_lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic [31:0] rdata_q;
    logic        err_q;

    lsu_err_e    err_d;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign err_d = lsu_check_req(req_we, req_funct3, req_addr, MEM_WORDS);

    lsu_lane_align u_align (
        .funct3     (funct3_q),
        .offset     (addr_q[1:0]),
        .word       (mem_rdata),
        .wdata      (wdata_q[15:0]),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            merge_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        rdata_q  <= 32'h0;
                        err_q    <= (err_d != ERR_NONE);
                        state_q  <= (err_d != ERR_NONE) ? S_RESP : S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!we_q) begin
                        rdata_q <= load_data;
                        state_q <= S_RESP;
                    end else if (funct3_q == F3_W) begin
                        state_q <= S_RESP;
                    end else begin
                        merge_q <= store_word;
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: state_q <= S_RESP;
                S_RESP: begin
                    if (resp_ready)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Outputs decode state plus registered request only, so an async reset
    // drops mem_we in the same instant it returns the FSM to IDLE.
    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_addr   = {2'b00, addr_q[31:2]};
    assign mem_we     = (state_q == S_WRITE) ||
                        (state_q == S_ACCESS && we_q && funct3_q == F3_W);
    assign mem_wdata  = (state_q == S_WRITE) ? merge_q : wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: behavioural word memory, a vector
// table driven through a response scoreboard, plus reset and backpressure cases.
module tb_load_store_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    logic [31:0] mem [0:31];
    logic        pre_we;
    logic [4:0]  pre_idx;
    logic [31:0] pre_data;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int rst_viol = 0;
    int we_base = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [2:0]  lat;
        logic [1:0]  wr;
    } exp_t;
    exp_t exp_q[$];

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [2:0]  lat;
        logic [1:0]  wr;
    } vec_t;
    vec_t vecs [21];

    load_store_unit #(.MEM_WORDS(32)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 CLK = ~CLK;

    assign mem_rdata = mem[mem_addr[4:0]];

    always @(posedge CLK) begin
        if (mem_we)
            mem[mem_addr[4:0]] <= mem_wdata;
        else if (pre_we)
            mem[pre_idx] <= pre_data;
        if (mem_we)
            we_cnt <= we_cnt + 1;
    end

    always @(posedge CLK or negedge CLK) begin
        if (!RST && mem_we)
            rst_viol <= rst_viol + 1;
    end

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic preload(input logic [4:0] idx, input logic [31:0] data);
        @(negedge CLK);
        pre_we = 1'b1; pre_idx = idx; pre_data = data;
        @(negedge CLK);
        pre_we = 1'b0;
    endtask

    // Returns at accept edge + 1 time unit, with req_valid released.
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = 0;
        @(negedge CLK);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        while (!req_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1");
        end
        @(posedge CLK);
        #1;
        we_base = we_cnt;
        req_valid = 1'b0;
    endtask

    // Called at accept edge + 1; cycle 1 is the cycle right after acceptance.
    task automatic collect(input int idx);
        int   cyc;
        exp_t e;
        cyc = 1;
        while (!resp_valid && cyc < 8) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty[%0d]: got 0 entries expected 1", idx);
            return;
        end
        e = exp_q.pop_front();
        chk("resp_valid", idx, 32'(resp_valid), 32'd1);
        chk("latency", idx, 32'(cyc), 32'(e.lat));
        chk("rdata", idx, resp_rdata, e.rdata);
        chk("err", idx, 32'(resp_err), 32'(e.err));
        if (resp_ready) begin
            @(posedge CLK);
            #1;
            chk("writes", idx, 32'(we_cnt - we_base), 32'(e.wr));
            chk("resp_drop", idx, 32'(resp_valid), 32'd0);
        end
    endtask

    task automatic run_vec(input int i);
        exp_q.push_back('{rdata: vecs[i].rdata, err: vecs[i].err, lat: vecs[i].lat, wr: vecs[i].wr});
        send(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
        collect(i);
    endtask

    initial begin
        RST = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
        pre_we = 1'b0; pre_idx = 5'd0; pre_data = 32'h0;

        //        we    f3      addr   wdata         rdata         err   lat  wr
        vecs[0]  = '{1'b0, 3'b000, 32'h09, 32'h0, 32'h0000007F, 1'b0, 3'd2, 2'd0};
        vecs[1]  = '{1'b0, 3'b100, 32'h09, 32'h0, 32'h0000007F, 1'b0, 3'd2, 2'd0};
        vecs[2]  = '{1'b0, 3'b000, 32'h0A, 32'h0, 32'hFFFFFFFF, 1'b0, 3'd2, 2'd0};
        vecs[3]  = '{1'b0, 3'b100, 32'h0A, 32'h0, 32'h000000FF, 1'b0, 3'd2, 2'd0};
        vecs[4]  = '{1'b0, 3'b000, 32'h0B, 32'h0, 32'hFFFFFF80, 1'b0, 3'd2, 2'd0};
        vecs[5]  = '{1'b0, 3'b001, 32'h0A, 32'h0, 32'hFFFF80FF, 1'b0, 3'd2, 2'd0};
        vecs[6]  = '{1'b0, 3'b101, 32'h0A, 32'h0, 32'h000080FF, 1'b0, 3'd2, 2'd0};
        vecs[7]  = '{1'b0, 3'b001, 32'h08, 32'h0, 32'h00007F01, 1'b0, 3'd2, 2'd0};
        vecs[8]  = '{1'b0, 3'b010, 32'h08, 32'h0, 32'h80FF7F01, 1'b0, 3'd2, 2'd0};
        vecs[9]  = '{1'b1, 3'b000, 32'h06, 32'h000000AB, 32'h0, 1'b0, 3'd3, 2'd1};
        vecs[10] = '{1'b0, 3'b010, 32'h04, 32'h0, 32'h11AB3344, 1'b0, 3'd2, 2'd0};
        vecs[11] = '{1'b1, 3'b001, 32'h04, 32'h1234BEEF, 32'h0, 1'b0, 3'd3, 2'd1};
        vecs[12] = '{1'b0, 3'b010, 32'h04, 32'h0, 32'h11ABBEEF, 1'b0, 3'd2, 2'd0};
        vecs[13] = '{1'b0, 3'b010, 32'h02, 32'h0, 32'h0, 1'b1, 3'd1, 2'd0};
        vecs[14] = '{1'b1, 3'b001, 32'h03, 32'h5555, 32'h0, 1'b1, 3'd1, 2'd0};
        vecs[15] = '{1'b0, 3'b010, 32'h80, 32'h0, 32'h0, 1'b1, 3'd1, 2'd0};
        vecs[16] = '{1'b0, 3'b011, 32'h08, 32'h0, 32'h0, 1'b1, 3'd1, 2'd0};
        vecs[17] = '{1'b1, 3'b100, 32'h08, 32'h77, 32'h0, 1'b1, 3'd1, 2'd0};
        vecs[18] = '{1'b1, 3'b010, 32'h7C, 32'hDEADBEEF, 32'h0, 1'b0, 3'd2, 2'd1};
        vecs[19] = '{1'b0, 3'b010, 32'h7C, 32'h0, 32'hDEADBEEF, 1'b0, 3'd2, 2'd0};
        vecs[20] = '{1'b0, 3'b101, 32'h7E, 32'h0, 32'h0000DEAD, 1'b0, 3'd2, 2'd0};

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_req_ready", 0, 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 0, 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", 0, resp_rdata, 32'h0);
        chk("rst_resp_err", 0, 32'(resp_err), 32'd0);
        chk("rst_mem_we", 0, 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 0, mem_addr, 32'h0);
        chk("rst_mem_wdata", 0, mem_wdata, 32'h0);
        @(negedge CLK);
        RST = 1'b1;

        preload(5'd2, 32'h80FF7F01);
        preload(5'd1, 32'h11223344);
        preload(5'd31, 32'h0);
        preload(5'd5, 32'h55667788);

        for (int i = 0; i < 21; i++)
            run_vec(i);
        chk("mem1_final", 1, mem[1], 32'h11ABBEEF);
        chk("mem31_final", 31, mem[31], 32'hDEADBEEF);
        chk("mem2_untouched", 2, mem[2], 32'h80FF7F01);

        // Backpressure: response held while a second request waits.
        resp_ready = 1'b0;
        exp_q.push_back('{rdata: 32'h80FF7F01, err: 1'b0, lat: 3'd2, wr: 2'd0});
        send(1'b0, 3'b010, 32'h08, 32'h0);
        collect(100);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h04;
            @(posedge CLK);
            #1;
            chk("bp_valid_hold", 100 + k, 32'(resp_valid), 32'd1);
            chk("bp_rdata_hold", 100 + k, resp_rdata, 32'h80FF7F01);
            chk("bp_req_ready", 100 + k, 32'(req_ready), 32'd0);
        end
        @(negedge CLK);
        resp_ready = 1'b1;
        @(posedge CLK);
        #1;
        chk("bp_after_hs_valid", 110, 32'(resp_valid), 32'd0);
        chk("bp_after_hs_ready", 110, 32'(req_ready), 32'd1);
        exp_q.push_back('{rdata: 32'h11ABBEEF, err: 1'b0, lat: 3'd2, wr: 2'd0});
        @(posedge CLK);
        #1;
        we_base = we_cnt;
        req_valid = 1'b0;
        chk("bp_accepted", 111, 32'(req_ready), 32'd0);
        collect(111);

        // Async reset while a sub-word store sits in WRITE.
        send(1'b1, 3'b000, 32'h14, 32'h000000CC);
        @(posedge CLK);
        #1;
        chk("rmw_in_write", 200, 32'(mem_we), 32'd1);
        RST = 1'b0;
        #1;
        chk("arst_mem_we", 200, 32'(mem_we), 32'd0);
        chk("arst_req_ready", 200, 32'(req_ready), 32'd1);
        chk("arst_resp_valid", 200, 32'(resp_valid), 32'd0);
        chk("arst_mem_addr", 200, mem_addr, 32'h0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        chk("arst_no_we", 200, 32'(rst_viol), 32'd0);
        chk("arst_mem5_kept", 200, mem[5], 32'h55667788);
        exp_q.push_back('{rdata: 32'h55667788, err: 1'b0, lat: 3'd2, wr: 2'd0});
        send(1'b0, 3'b010, 32'h14, 32'h0);
        collect(201);

        chk("sb_drained", 300, 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
